// File: rtl/emb_lut_stream.sv
// Streaming table lookup with a 4-entry response FIFO and a loadable table.
// Define EMB_LUT_OREG_EN to add an output register after the array read (latency 2 instead of 1).
`timescale 1ns/1ps
module emb_lut_stream #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic [DATA_W-1:0] fifo_data_q [0:3];
  logic [3:0]        fifo_err_q;
  logic [1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0]        count_q, count_d;
  logic              rdy_q;

  logic              accept_s, rd_en_s, rd_range_s, wr_range_s;
  logic              push_s, pop_s, push_err_s, inflight_s;
  logic [DATA_W-1:0] push_data_s;
  logic [IDX_W-1:0]  rd_idx_s, wr_idx_s;
  logic [3:0]        occupancy_s;

  assign rd_range_s  = ({1'b0, in_addr} < DEPTH_C);
  assign wr_range_s  = ({1'b0, wr_addr} < DEPTH_C);
  assign rd_idx_s    = in_addr[IDX_W-1:0];
  assign wr_idx_s    = wr_addr[IDX_W-1:0];
  assign occupancy_s = {1'b0, count_q} + {3'b000, inflight_s};
  assign in_ready    = rdy_q & ~wr_en & (occupancy_s < 4'd4);
  assign accept_s    = in_valid & in_ready;
  // Out-of-range lookups never touch the array; the enable is also low when idle.
  assign rd_en_s     = accept_s & rd_range_s;
  assign out_valid   = (count_q != 3'd0);
  assign pop_s       = out_valid & out_ready;
  assign out_data    = out_valid ? fifo_data_q[rptr_q] : {DATA_W{1'b0}};
  assign out_err     = out_valid & fifo_err_q[rptr_q];

  // Table load port; writes beyond DEPTH are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (wr_en && wr_range_s) begin
      mem_q[wr_idx_s] <= wr_data;
    end
  end

`ifdef EMB_LUT_OREG_EN
  logic              pipe_v_q;
  logic [DATA_W-1:0] pipe_data_q;
  logic              pipe_err_q;

  // Validity of the read stage; cleared by reset so nothing in flight survives it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v_q <= 1'b0;
    end else begin
      pipe_v_q <= accept_s;
    end
  end

  // Synchronous array read into the extra output register.
  always_ff @(posedge clk) begin
    if (rd_en_s) begin
      pipe_data_q <= mem_q[rd_idx_s];
    end else if (accept_s) begin
      pipe_data_q <= {DATA_W{1'b0}};
    end
    if (accept_s) begin
      pipe_err_q <= ~rd_range_s;
    end
  end

  assign push_s      = pipe_v_q;
  assign push_data_s = pipe_data_q;
  assign push_err_s  = pipe_err_q;
  assign inflight_s  = pipe_v_q;
`else
  // Array output is captured straight into the FIFO slot at the accept edge.
  always_comb begin
    push_data_s = {DATA_W{1'b0}};
    if (rd_en_s) begin
      push_data_s = mem_q[rd_idx_s];
    end else begin
      push_data_s = {DATA_W{1'b0}};
    end
  end

  assign push_s     = accept_s;
  assign push_err_s = ~rd_range_s;
  assign inflight_s = 1'b0;
`endif

  // FIFO storage; content is only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_data_q[wptr_q] <= push_data_s;
      fifo_err_q[wptr_q]  <= push_err_s;
    end
  end

  // Pointer and occupancy next-state; simultaneous push and pop keeps the count.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_s) begin
      wptr_d = wptr_q + 2'd1;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + 2'd1;
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Control registers; rdy_q keeps in_ready low while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= 2'd0;
      rptr_q  <= 2'd0;
      count_q <= 3'd0;
      rdy_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_emb_lut_stream.sv
// Self-checking bench for emb_lut_stream: queue-based reference model plus directed scenarios.
`timescale 1ns/1ps
module tb_emb_lut_stream;

`ifdef EMB_LUT_OREG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int DEP = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_err;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  emb_lut_stream #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data));

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            acyc;
  } rsp_t;

  rsp_t          mq[$];
  logic [DW-1:0] mmem [0:DEP-1];
  int            cyc = 0;
  bit            mrdy = 1'b0;
  int            tests = 0;
  int            fails = 0;
  int            dut_acc = 0;
  logic [DW-1:0] log_d[$];
  logic          log_e[$];
  int            log_c[$];
  int            acc_c[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: outstanding responses in order, each visible L edges after its accept edge.
  always @(posedge clk) begin
    bit   mv;
    bit   acc;
    rsp_t r;
    cyc++;
    if (reset) begin
      mq.delete();
      mrdy = 1'b0;
    end else begin
      mv  = (mq.size() > 0) && (mq[0].acyc + L - 1 <= cyc - 1);
      acc = in_valid && mrdy && !wr_en && (mq.size() < 4);
      if (mv && out_ready) void'(mq.pop_front());
      if (acc) begin
        r.err  = (in_addr >= DEP);
        r.data = r.err ? '0 : mmem[in_addr];
        r.acyc = cyc;
        mq.push_back(r);
        acc_c.push_back(cyc);
      end
      if (wr_en && wr_addr < DEP) mmem[wr_addr] = wr_data;
      mrdy = 1'b1;
    end
  end

  // Cycle-by-cycle comparison of every output against the model, plus a log of consumed responses.
  always @(negedge clk) begin
    bit ev;
    bit er;
    ev = !reset && (mq.size() > 0) && (mq[0].acyc + L - 1 <= cyc);
    er = !reset && mrdy && !wr_en && (mq.size() < 4);
    chk("out_valid", {63'd0, out_valid}, {63'd0, ev});
    chk("in_ready", {63'd0, in_ready}, {63'd0, er});
    if (ev) begin
      chk("out_data", {32'd0, out_data}, {32'd0, mq[0].data});
      chk("out_err", {63'd0, out_err}, {63'd0, mq[0].err});
    end
    if (!reset && in_valid && in_ready) dut_acc++;
    if (!reset && out_valid && out_ready) begin
      log_d.push_back(out_data);
      log_e.push_back(out_err);
      log_c.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_d.delete();
    log_e.delete();
    log_c.delete();
    acc_c.delete();
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && mq.size() > 0; k++) step();
    step();
    chk("drain_timeout", 64'(mq.size()), 64'd0);
  endtask

  initial begin
    int acc0;
    #1 reset = 1'b1;
    #3;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_err", {63'd0, out_err}, 64'd0);
    step();
    step();
    reset = 1'b0;
    step();
    chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Load the whole table with a few pinned values.
    for (int i = 0; i < DEP; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      if (i < 8) wr_data = 32'hA000_0000 + 32'(i);
      else if (i == 476) wr_data = 32'h0476_0476;
      else wr_data = $urandom;
      step();
    end
    wr_en = 1'b0;

    // Back-to-back reads of the pinned entries.
    clear_logs();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'(i);
      step();
    end
    in_valid = 1'b0;
    drain();
    chk("seq_count", 64'(log_d.size()), 64'd8);
    for (int i = 0; i < 8 && i < log_d.size(); i++)
      chk("seq_data", {32'd0, log_d[i]}, {32'd0, 32'hA000_0000 + 32'(i)});
    if (log_c.size() == 8 && acc_c.size() > 0) begin
      chk("seq_latency", 64'(log_c[0] - acc_c[0] + 1), 64'(L));
      chk("seq_no_gaps", 64'(log_c[7] - log_c[0]), 64'd7);
    end else begin
      chk("seq_logged", 64'(log_c.size()), 64'd8);
    end

    // Backpressure: only four requests may be outstanding.
    clear_logs();
    out_ready = 1'b0;
    acc0 = dut_acc;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'($urandom_range(0, DEP - 1));
      step();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 64'(dut_acc - acc0), 64'd4);
    chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    drain();
    chk("bp_released", 64'(log_d.size()), 64'd4);

    // Write priority and read-after-write.
    clear_logs();
    wr_en = 1'b1; wr_addr = 11'd5; wr_data = 32'h1234_5678;
    in_valid = 1'b1; in_addr = 11'd5;
    #2 chk("wr_blocks_ready", {63'd0, in_ready}, 64'd0);
    step();
    wr_en = 1'b0;
    step();
    in_valid = 1'b0;
    drain();
    chk("raw_count", 64'(log_d.size()), 64'd1);
    if (log_d.size() > 0) chk("raw_data", {32'd0, log_d[0]}, 64'h1234_5678);

    // Out-of-range read and ignored out-of-range write (1500 would alias 476).
    clear_logs();
    in_valid = 1'b1; in_addr = 11'd1500;
    step();
    in_valid = 1'b0;
    wr_en = 1'b1; wr_addr = 11'd1500; wr_data = 32'hDEAD_BEEF;
    step();
    wr_en = 1'b0;
    in_valid = 1'b1; in_addr = 11'd476;
    step();
    in_valid = 1'b0;
    drain();
    chk("oor_count", 64'(log_d.size()), 64'd2);
    if (log_d.size() == 2) begin
      chk("oor_data", {32'd0, log_d[0]}, 64'd0);
      chk("oor_err", {63'd0, log_e[0]}, 64'd1);
      chk("alias_data", {32'd0, log_d[1]}, 64'h0476_0476);
      chk("alias_err", {63'd0, log_e[1]}, 64'd0);
    end

    // Randomized traffic including writes, out-of-range addresses and stalls.
    for (int i = 0; i < 3000; i++) begin
      wr_en     = ($urandom_range(0, 9) == 0);
      wr_addr   = AW'($urandom_range(0, 1099));
      wr_data   = $urandom;
      in_valid  = ($urandom_range(0, 2) != 0);
      in_addr   = AW'($urandom_range(0, 1099));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Reset with three responses buffered.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'(20 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("buffered_valid", {63'd0, out_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_in_ready", {63'd0, in_ready}, 64'd0);
    chk("async_out_data", {32'd0, out_data}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_logs();
    out_ready = 1'b1;
    step();
    chk("ready_after_rst2", {63'd0, in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'(30 + i);
      step();
    end
    in_valid = 1'b0;
    drain();
    chk("no_stale_count", 64'(log_d.size()), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
